// File: rtl/inv_mixcol_ctrl.sv
// inv_mixcol_ctrl: sequenced AES InvMixColumns engine (define INV_MIXCOL_COLPAR_EN for column-parallel mode)
module inv_mixcol_ctrl (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] state_in,
    output logic [127:0] state_out,
    output logic         busy,
    output logic         done
);
    typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;
    state_t state, nstate;
    logic [3:0] cnt;
    logic [127:0] src, res, res_nxt;
    logic [31:0] col;
    logic load, last;
`ifdef INV_MIXCOL_COLPAR_EN
    localparam logic [3:0] LAST_CNT = 4'd3;
`else
    localparam logic [3:0] LAST_CNT = 4'd15;
`endif
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] k);
        logic [7:0] a2, a4, a8;
        a2 = xt(a);
        a4 = xt(a2);
        a8 = xt(a4);
        return (k[3] ? a8 : 8'h00) ^ (k[2] ? a4 : 8'h00) ^ (k[1] ? a2 : 8'h00) ^ (k[0] ? a : 8'h00);
    endfunction
    function automatic logic [7:0] pick(input logic [31:0] c, input logic [1:0] j);
        return j == 2'd0 ? c[31:24] : j == 2'd1 ? c[23:16] : j == 2'd2 ? c[15:8] : c[7:0];
    endfunction
    function automatic logic [31:0] colsel(input logic [127:0] s, input logic [1:0] c);
        return c == 2'd0 ? s[127:96] : c == 2'd1 ? s[95:64] : c == 2'd2 ? s[63:32] : s[31:0];
    endfunction
    function automatic logic [7:0] inv_byte(input logic [31:0] c, input logic [1:0] r);
        return gmul(pick(c, r), 4'he) ^ gmul(pick(c, r + 2'd1), 4'hb) ^
               gmul(pick(c, r + 2'd2), 4'hd) ^ gmul(pick(c, r + 2'd3), 4'h9);
    endfunction
    // merge the bytes produced this cycle into the result register image
    always_comb begin
        res_nxt = res;
`ifdef INV_MIXCOL_COLPAR_EN
        col = colsel(src, cnt[1:0]);
        for (int k = 0; k < 4; k++)
            if (cnt == 4'(k))
                res_nxt[127-32*k -: 32] = {inv_byte(col, 2'd0), inv_byte(col, 2'd1), inv_byte(col, 2'd2), inv_byte(col, 2'd3)};
`else
        col = colsel(src, cnt[3:2]);
        for (int k = 0; k < 16; k++)
            if (cnt == 4'(k))
                res_nxt[127-8*k -: 8] = inv_byte(col, cnt[1:0]);
`endif
    end
    // next-state logic; start only matters in IDLE
    always_comb begin
        nstate = state;
        load = 1'b0;
        last = cnt == LAST_CNT;
        case (state)
            IDLE: begin
                load = start;
                nstate = start ? COMPUTE : IDLE;
            end
            COMPUTE: nstate = last ? DONE : COMPUTE;
            default: nstate = IDLE;
        endcase
    end
    // state register with busy/done registered from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            state <= nstate;
            busy <= nstate != IDLE;
            done <= nstate == DONE;
        end
    end
    // datapath: capture on accept, accumulate bytes, publish only on the last write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src <= '0;
            res <= '0;
            state_out <= '0;
            cnt <= '0;
        end else if (load) begin
            src <= state_in;
            cnt <= '0;
        end else if (state == COMPUTE) begin
            res <= res_nxt;
            cnt <= cnt + 4'd1;
            if (last)
                state_out <= res_nxt;
        end
    end
endmodule

// File: tb/tb_inv_mixcol_ctrl.sv
// tb_inv_mixcol_ctrl: scoreboard bench for the InvMixColumns engine
module tb_inv_mixcol_ctrl;
`ifdef INV_MIXCOL_COLPAR_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 16;
`endif
    localparam int PER = LAT + 2;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [127:0] state_in = '0;
    logic [127:0] state_out;
    logic busy, done;
    int total = 0, bad = 0;
    logic [127:0] sb[$];

    inv_mixcol_ctrl dut (.clk(clk), .rst(rst), .start(start), .state_in(state_in),
                         .state_out(state_out), .busy(busy), .done(done));

    always #5 clk = ~clk;

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p ^= a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] mat(input logic [127:0] s, input logic [7:0] k0, input logic [7:0] k1,
                                         input logic [7:0] k2, input logic [7:0] k3);
        logic [127:0] o;
        logic [7:0] b[4];
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int j = 0; j < 4; j++) b[j] = s[127-32*c-8*j -: 8];
            for (int r = 0; r < 4; r++)
                o[127-32*c-8*r -: 8] = gm(b[r], k0) ^ gm(b[(r+1)%4], k1) ^ gm(b[(r+2)%4], k2) ^ gm(b[(r+3)%4], k3);
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_ref(input logic [127:0] s);
        return mat(s, 8'h0e, 8'h0b, 8'h0d, 8'h09);
    endfunction

    function automatic logic [127:0] mix_ref(input logic [127:0] s);
        return mat(s, 8'h02, 8'h03, 8'h01, 8'h01);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [127:0] d, input logic [127:0] exp);
        start = 1'b1;
        state_in = d;
        sb.push_back(exp);
        tick;
        start = 1'b0;
        state_in = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic wait_done(input bit poke);
        int n;
        int seen;
        logic [127:0] exp;
        n = 0;
        while (done !== 1'b1 && n < 60) begin
            tick;
            n++;
        end
        total++;
        if (n != LAT) begin
            bad++;
            $display("FAIL latency: got %0d cycles, want %0d", n, LAT);
        end
        exp = 'x;
        if (sb.size() != 0) exp = sb.pop_front();
        total++;
        if (state_out !== exp) begin
            bad++;
            $display("FAIL result: got %h want %h", state_out, exp);
        end
        if (poke) begin
            start = 1'b1;
            state_in = ~state_in;
        end
        tick;
        start = 1'b0;
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL after_done: done=%b busy=%b want 0 0", done, busy);
        end
        if (poke) begin
            seen = 0;
            repeat (PER) begin
                tick;
                if (done !== 1'b0 || busy !== 1'b0) seen++;
            end
            total++;
            if (seen != 0 || state_out !== exp) begin
                bad++;
                $display("FAIL start_in_done: %0d active cycles, out=%h want 0 and %h", seen, state_out, exp);
            end
        end
    endtask

    task automatic test_reset;
        repeat (2) tick;
        total++;
        if (state_out !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset: out=%h busy=%b done=%b want 0", state_out, busy, done);
        end
        rst = 1'b0;
        tick;
    endtask

    task automatic test_vectors;
        issue(128'h8e4da1bc_00000000_00000000_00000000, 128'hdb135345_00000000_00000000_00000000);
        wait_done(1'b0);
        issue(128'h01010101_c6c6c6c6_d5d5d7d6_4d7ebdf8, 128'h01010101_c6c6c6c6_d4d4d4d5_2d26314c);
        wait_done(1'b0);
    endtask

    task automatic test_back_to_back;
        logic [127:0] d, exp;
        d = 128'h0123456789abcdeffedcba9876543210;
        start = 1'b1;
        state_in = d;
        for (int i = 0; i < 3 * PER; i++) begin
            if (i % PER == 0) sb.push_back(inv_ref(d));
            tick;
            total++;
            if (done !== (i % PER == LAT) || busy !== (i % PER <= LAT)) begin
                bad++;
                $display("FAIL b2b_handshake: cycle %0d done=%b busy=%b want %b %b", i, done, busy,
                         i % PER == LAT, i % PER <= LAT);
            end
            if (done === 1'b1) begin
                exp = sb.size() != 0 ? sb.pop_front() : 'x;
                total++;
                if (state_out !== exp) begin
                    bad++;
                    $display("FAIL b2b_result: got %h want %h", state_out, exp);
                end
            end
        end
        start = 1'b0;
        tick;
    endtask

    task automatic test_reset_mid;
        int seen;
        issue(128'h00112233445566778899aabbccddeeff, 128'h0);
        void'(sb.pop_back());
        repeat (LAT > 7 ? 6 : 2) tick;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL mid_busy: got %b want 1", busy);
        end
        rst = 1'b1;
        #1;
        total++;
        if (state_out !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset: out=%h busy=%b done=%b want 0", state_out, busy, done);
        end
        tick;
        rst = 1'b0;
        seen = 0;
        repeat (2 * LAT) begin
            tick;
            if (done !== 1'b0) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL mid_no_done: got %0d done cycles want 0", seen);
        end
        issue(128'h00112233445566778899aabbccddeeff, inv_ref(128'h00112233445566778899aabbccddeeff));
        wait_done(1'b0);
    endtask

    task automatic test_start_in_done;
        issue(128'hd4bf5d30e0b452aeb84111f11e2798e5, inv_ref(128'hd4bf5d30e0b452aeb84111f11e2798e5));
        wait_done(1'b1);
    endtask

    task automatic test_random;
        logic [127:0] d;
        for (int i = 0; i < 1000; i++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            total++;
            if (mix_ref(inv_ref(d)) !== d) begin
                bad++;
                $display("FAIL model_inverse: got %h want %h", mix_ref(inv_ref(d)), d);
            end
            issue(d, inv_ref(d));
            wait_done(1'b0);
        end
    endtask

    initial begin
        test_reset;
        test_vectors;
        test_back_to_back;
        test_reset_mid;
        test_start_in_done;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
